// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin multiplexing arbiter:
// mode encodings, transfer-counter width and a saturating increment helper.
package rr_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational circular search: finds the first set request bit at or after
// i_start, wrapping from N-1 back to 0, and reports its absolute index.
module rr_arb_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_start,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IW = $clog2(N);

    // Requests rotated so that bit 0 corresponds to the start index.
    logic [N-1:0] w_rot;
    logic [IW:0]  w_sum;

    assign w_rot = N'({i_req, i_req} >> i_start);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_start} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N)) begin
                    w_sum = w_sum - (IW+1)'(N);
                end
                o_idx = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel to one multiplexing arbiter with a single registered output word.
// mode selects fixed priority (lowest index) or round robin after the last
// accepted channel. A new word is accepted whenever the output register is
// empty or being drained in the same cycle, so back-to-back transfers run at
// one word per clock.
// Optional feature: define RR_MUX_ARBITER_CNT_EN to add the 16-bit saturating
// xfer_count output counting words taken downstream.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int W = 2,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef RR_MUX_ARBITER_CNT_EN
    output logic [CNT_W-1:0]     xfer_count,
`endif
    output logic [$clog2(N)-1:0] grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_last;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;

    logic          w_take;
    logic          w_space;
    logic          w_found;
    logic          w_accept;
    logic [IW-1:0] w_start;
    logic [IW-1:0] w_pick;
    logic [W-1:0]  w_sel_data;

    assign w_take  = r_out_valid & out_ready;
    assign w_space = ~r_out_valid | w_take;

    // Search origin: channel 0 in fixed priority, one past the last winner
    // in round robin.
    always_comb begin
        w_start = '0;
        if (mode == MODE_RR) begin
            w_start = (r_last == IW'(N - 1)) ? '0 : r_last + 1'b1;
        end
    end

    rr_arb_pick #(
        .N (N)
    ) u_pick (
        .i_req   (in_valid),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // rst_n gates the handshake so nothing is offered while reset is held.
    assign w_accept = rst_n & w_space & w_found;

    // One-hot accept strobe and grant index for the current cycle.
    always_comb begin
        in_ready = '0;
        grant    = '0;
        if (w_accept) begin
            grant = w_pick;
            for (int i = 0; i < N; i++) begin
                in_ready[i] = (w_pick == IW'(i));
            end
        end
    end

    // Only the picked channel's slice reaches the output register.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick == IW'(i)) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output word register: load on accept, empty on a take with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer follows every accepted transfer in either mode;
    // reset value N-1 makes the first round-robin search begin at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(N - 1);
        end else if (w_accept) begin
            r_last <= w_pick;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef RR_MUX_ARBITER_CNT_EN
    logic [CNT_W-1:0] r_xfer_count;

    // Count words leaving through the output handshake, saturating at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_take) begin
            r_xfer_count <= sat_inc(r_xfer_count);
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N=4, W=2, default build).
// A cycle-level reference model tracks the output word, its valid flag and
// the round-robin pointer; directed sequences plus randomized traffic.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     grant;

    int n_chk;
    int n_pass;

    // reference model state
    logic           m_valid;
    logic [W-1:0]   m_data;
    int             m_last;

    // results of the most recent modelled cycle
    int             last_grant;
    logic [N-1:0]   last_ready;

    rr_mux_arbiter #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = N - 1;
    endtask

    // One clock: apply inputs, check outputs against the model, advance model.
    task automatic cycle(input logic [N-1:0] v, input logic md, input logic ordy,
                         input logic [N*W-1:0] d);
        logic take;
        logic space;
        int   pick;
        int   c;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        in_valid  = v;
        mode      = md;
        out_ready = ordy;
        in_data   = d;
        #1;
        take  = m_valid && ordy;
        space = !m_valid || take;
        pick  = -1;
        if (space) begin
            for (int s = 0; s < N; s++) begin
                c = md ? (m_last + 1 + s) % N : s;
                if (v[c]) begin
                    pick = c;
                    break;
                end
            end
        end
        exp_ready = '0;
        if (pick >= 0) exp_ready[pick] = 1'b1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_data", {30'b0, out_data}, {30'b0, m_data});
        chk("in_ready", {28'b0, in_ready}, {28'b0, exp_ready});
        chk("grant", {30'b0, grant}, (pick >= 0) ? pick : 0);
        last_grant = (pick >= 0) ? pick : 0;
        last_ready = exp_ready;
        @(posedge clk);
        if (pick >= 0) begin
            m_valid = 1'b1;
            m_data  = d[pick*W +: W];
            m_last  = pick;
        end else if (take) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        mode      = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'($urandom);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {30'b0, out_data}, 0);
        chk("rst_in_ready", {28'b0, in_ready}, 0);
        chk("rst_grant", {30'b0, grant}, 0);
        @(negedge clk);
        @(negedge clk);
        in_valid  = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        model_reset();
    endtask

    int rr_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // round robin over all four requesters
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1, 1'b1, 8'($urandom));
            chk("rr_seq", last_grant, rr_seq[k]);
        end

        // fixed priority starves channel 3
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1010, 1'b0, 1'b1, 8'($urandom));
            chk("fixed_grant", last_grant, 1);
            chk("fixed_ready", {28'b0, last_ready}, 32'h2);
        end

        // stall with a held word from channel 2, then refill in the take cycle
        do_reset();
        cycle(4'b0100, 1'b0, 1'b1, 8'h30);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 1'b0, 8'($urandom));
            chk("stall_data", {30'b0, out_data}, 3);
            chk("stall_ready", {28'b0, last_ready}, 0);
        end
        cycle(4'b0001, 1'b0, 1'b1, 8'h02);
        chk("refill_ready", {28'b0, last_ready}, 32'h1);
        cycle(4'b0000, 1'b0, 1'b0, 8'($urandom));
        chk("refill_data", {30'b0, out_data}, 2);

        // drain with no requests, pointer kept at 1, then wrap to channel 3
        do_reset();
        cycle(4'b0010, 1'b1, 1'b1, 8'($urandom));
        cycle(4'b0000, 1'b1, 1'b1, 8'($urandom));
        cycle(4'b0000, 1'b1, 1'b1, 8'($urandom));
        chk("drained_valid", {31'b0, out_valid}, 0);
        cycle(4'b1001, 1'b1, 1'b1, 8'($urandom));
        chk("rr_after_drain", last_grant, 3);

        // asynchronous reset while a word is held
        cycle(4'b0100, 1'b1, 1'b1, 8'($urandom));
        @(negedge clk);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #2;
        chk("pre_async_valid", {31'b0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 0);
        chk("async_data", {30'b0, out_data}, 0);
        chk("async_ready", {28'b0, in_ready}, 0);
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        model_reset();
        cycle(4'b1111, 1'b1, 1'b1, 8'($urandom));
        chk("post_reset_rr", last_grant, 0);

        // randomized traffic with mode changes
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 4) == 0) ? '0 : 4'($urandom);
            cycle(v, 1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter W, default 2: data width per channel, range 1 to 32.
REQ-002 Parameter N, default 4: channel count, range 2 to 16.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_data  in  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-007 in_valid  in  N  per-channel request.
REQ-008 in_ready  out  N  per-channel accept; at most one bit is high in any cycle.
REQ-009 mode  in  1  0 = fixed priority (lowest index wins); 1 = round robin.
REQ-010 out_data  out  W  registered selected data.
REQ-011 out_valid  out  1  out_data holds an untaken word.
REQ-012 out_ready  in  1  downstream accept.
REQ-013 grant  out  $clog2(N)  index of the channel accepted in the current cycle; 0 when none.

Function
REQ-014 Define take = out_valid & out_ready, and space = ~out_valid | take.
REQ-015 When space is high and any in_valid bit is high, exactly one channel SHALL be picked, with in_ready[pick] = 1; all other in_ready bits are 0; in_ready is combinational.
REQ-016 mode=0: pick = lowest index i with in_valid[i] = 1.
REQ-017 mode=1: pick = first i with in_valid[i] = 1, searching last+1, last+2, ... with wrap from N-1 to 0; last is the pointer register.
REQ-018 last SHALL update to pick only on an accepted transfer; mode=0 transfers also update last.
REQ-019 On accept, out_data SHALL load in_data of pick and out_valid SHALL be 1 on the next edge (latency 1 cycle).
REQ-020 If take is high and no channel is accepted, out_valid SHALL clear on the next edge and out_data SHALL hold its value.
REQ-021 A simultaneous take and accept SHALL sustain one word per cycle with no bubble.
REQ-022 With out_valid=1 and out_ready=0, all in_ready bits SHALL be 0 and out_data SHALL be stable.
REQ-023 A mode change takes effect on the next pick; last is not modified by the change.
REQ-024 in_data of a non-accepted channel SHALL NOT affect any output.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, last=N-1 (so the first round-robin search starts at 0), and in_ready=0.
REQ-026 Reset asserted mid-transfer SHALL discard the held word with no partial output; operation resumes on the first edge after deassertion.

Configuration
REQ-027 Macro RR_MUX_ARBITER_CNT_EN, when defined, SHALL add output xfer_count (16 bits), which increments on every take, saturates at 16'hFFFF, and resets to 0.
REQ-028 Without RR_MUX_ARBITER_CNT_EN, the xfer_count port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package rr_mux_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the counter width constant CNT_W=16.
REQ-030 Sub-module rr_arb_pick SHALL be a combinational search (inputs: request vector and start index; outputs: found and index), instanced once; the start index is 0 for mode=0 and last+1 mod N for mode=1.

Verification (N=4, W=2)
REQ-031 Reset, then in_valid=4'b1111, mode=1, out_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; out_data follows with 1 cycle delay.
REQ-032 mode=0, in_valid=4'b1010, out_ready=1 -> grant=1 every cycle; channel 3 starved; in_ready=4'b0010.
REQ-033 Accept word 2'b11 from channel 2, then out_ready=0 for 3 cycles -> out_valid=1, out_data=2'b11 stable, in_ready=0; on out_ready=1, the next word loads in the same cycle.
REQ-034 in_valid=0 while a word drains -> out_valid falls 1 cycle after take; last is unchanged; the next request on channel 3 with mode=1 and last=1 -> grant=3.
REQ-035 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately (asynchronous); after release, the first round-robin grant is channel 0.
REQ-036 With RR_MUX_ARBITER_CNT_EN defined, 65540 takes -> xfer_count=16'hFFFF; reset -> 0.
